// File: rtl/kamacore_mem_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter.
// Covers the instruction-fetch port, the load/store port, the shared
// single-port memory and the busy flag. The arbiter uses the slave view.
// The requesters and the memory model use the master view.
interface kamacore_mem_arbiter_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 if_req;
  logic [CPU_WIDTH-1:0] if_addr;
  logic [CPU_WIDTH-1:0] if_rdata;
  logic                 if_ack;

  logic                 ls_req;
  logic                 ls_we;
  logic [CPU_WIDTH-1:0] ls_addr;
  logic [CPU_WIDTH-1:0] ls_wdata;
  logic [CPU_WIDTH-1:0] ls_rdata;
  logic                 ls_ack;

  logic [CPU_WIDTH-1:0] mem_a;
  logic                 mem_we;
  logic [CPU_WIDTH-1:0] mem_di;
  logic [CPU_WIDTH-1:0] mem_spo;

  logic                 busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_spo,
    output if_rdata, if_ack, ls_rdata, ls_ack, mem_a, mem_we, mem_di, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_spo,
    input  if_rdata, if_ack, ls_rdata, ls_ack, mem_a, mem_we, mem_di, busy
  );
endinterface

// File: rtl/kamacore_mem_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch
// and load/store. Each grant runs through IDLE -> ACCESS (LATENCY cycles)
// -> DONE. The memory address and data come from the values latched at
// grant, so requester inputs may change freely once a grant is made.
// When both sides request together, the one that did not win last time
// gets the grant.
module kamacore_mem_arbiter #(
  parameter int CPU_WIDTH = 32,
  parameter int LATENCY   = 1
) (
  input logic                   clk,
  input logic                   rst,
  kamacore_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);
  localparam logic       GNT_IF   = 1'b0;
  localparam logic       GNT_LS   = 1'b1;

  state_t               state;
  logic [3:0]           cnt;
  logic                 last_grant;
  logic                 win;
  logic                 we_q;
  logic [CPU_WIDTH-1:0] addr_q;
  logic [CPU_WIDTH-1:0] wdata_q;
  logic [CPU_WIDTH-1:0] if_rdata_q;
  logic [CPU_WIDTH-1:0] ls_rdata_q;
  logic                 if_ack_q;
  logic                 ls_ack_q;
  logic                 pick_ls;
  logic                 final_cyc;

  // Grant selection: a lone requester wins; on a tie, the requester that did not win last time wins.
  always_comb begin
    pick_ls = bus.ls_req && (!bus.if_req || (last_grant == GNT_IF));
  end

  assign final_cyc = (state == ACCESS) && (cnt == LAST_CNT);

  // Request FSM: latch on grant, count access cycles, capture read data, pulse ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= GNT_IF;
      win        <= GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      ls_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.ls_req) begin
            state      <= ACCESS;
            cnt        <= 4'd0;
            win        <= pick_ls;
            last_grant <= pick_ls;
            if (pick_ls) begin
              addr_q  <= bus.ls_addr;
              we_q    <= bus.ls_we;
              wdata_q <= bus.ls_wdata;
            end else begin
              addr_q <= bus.if_addr;
              we_q   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == LAST_CNT) begin
            state    <= DONE;
            if_ack_q <= (win == GNT_IF);
            ls_ack_q <= (win == GNT_LS);
            if (win == GNT_IF) begin
              if_rdata_q <= bus.mem_spo;
            end else if (!we_q) begin
              ls_rdata_q <= bus.mem_spo;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are also gated by rst, so a reset asserted mid-access suppresses them in that same cycle.
  assign bus.mem_we   = final_cyc && (win == GNT_LS) && we_q && rst;
  assign bus.if_ack   = if_ack_q && rst;
  assign bus.ls_ack   = ls_ack_q && rst;
  assign bus.mem_a    = addr_q;
  assign bus.mem_di   = wdata_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.busy     = (state != IDLE);

endmodule
